// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush/halt controller
// Optional miss-timeout abort is enabled by defining PIPE_STALL_MISS_TIMEOUT_EN.
module pipe_stall_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MISS_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall_ld,
    input  logic       dc_miss,
    input  logic       dc_fill_done,
    input  logic       jump_req,
    input  logic       cpu_run,
    output logic       stall,
    output logic       stall_dly,
    output logic       stall_ex,
    output logic       stall_ma,
    output logic       stall_wb,
    output logic       stall_fin2,
    output logic       rst_pipe,
    output logic [2:0] ctrl_state,
    output logic       miss_timeout_err
);

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_LDSTALL = 3'd1,
        S_MISS    = 3'd2,
        S_FLUSH   = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_flush_cnt;
    logic       r_stall_dly;
    logic       r_stall_fin2;
    logic       w_stall;
    logic       w_stall_ex;
    logic       w_stall_ma;
    logic       w_stall_wb;
    logic       w_rst_pipe;

`ifdef PIPE_STALL_MISS_TIMEOUT_EN
    logic [7:0] r_miss_cnt;
    logic       r_miss_timeout_err;
    logic       w_miss_timeout;

    assign w_miss_timeout = (r_miss_cnt == 8'(MISS_TIMEOUT - 1));

    // Counter is zero in the first MISS cycle, so the MISS_TIMEOUT-th cycle aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miss_cnt         <= '0;
            r_miss_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_RUN && dc_miss) begin
                r_miss_cnt <= '0;
            end else if (r_state == S_MISS) begin
                r_miss_cnt <= r_miss_cnt + 8'd1;
                if (!dc_fill_done && w_miss_timeout) begin
                    r_miss_timeout_err <= 1'b1;
                end
            end
        end
    end

    assign miss_timeout_err = r_miss_timeout_err;
`else
    logic [7:0] w_unused_miss_timeout;
    assign w_unused_miss_timeout = 8'(MISS_TIMEOUT);
    assign miss_timeout_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RUN;
            r_flush_cnt  <= '0;
            r_stall_dly  <= 1'b0;
            r_stall_fin2 <= 1'b0;
        end else begin
            r_stall_dly  <= w_stall;
            r_stall_fin2 <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (dc_miss) begin
                        r_state <= S_MISS;
                    end else if (jump_req) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= FLUSH_LOAD;
                    end else if (stall_ld) begin
                        r_state <= S_LDSTALL;
                    end else if (!cpu_run) begin
                        r_state <= S_HALT;
                    end
                end
                S_LDSTALL: r_state <= S_RUN;
                S_MISS: begin
                    if (dc_fill_done) begin
                        r_state      <= S_RUN;
                        r_stall_fin2 <= 1'b1;
                    end
`ifdef PIPE_STALL_MISS_TIMEOUT_EN
                    else if (w_miss_timeout) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= FLUSH_LOAD;
                    end
`endif
                end
                S_FLUSH: begin
                    if (r_flush_cnt == 4'd0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 4'd1;
                    end
                end
                S_HALT: begin
                    if (cpu_run) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    // RUN outputs are Mealy so a hazard freezes the front end in the cycle it is raised.
    always_comb begin
        w_stall    = 1'b0;
        w_stall_ex = 1'b0;
        w_stall_ma = 1'b0;
        w_stall_wb = 1'b0;
        w_rst_pipe = 1'b0;
        case (r_state)
            S_RUN: begin
                if (dc_miss) begin
                    w_stall    = 1'b1;
                    w_stall_ex = 1'b1;
                    w_stall_ma = 1'b1;
                    w_stall_wb = 1'b1;
                end else if (!jump_req && stall_ld) begin
                    w_stall = 1'b1;
                end
            end
            S_LDSTALL: begin
                w_stall    = 1'b1;
                w_stall_ex = 1'b1;
            end
            S_MISS, S_HALT: begin
                w_stall    = 1'b1;
                w_stall_ex = 1'b1;
                w_stall_ma = 1'b1;
                w_stall_wb = 1'b1;
            end
            S_FLUSH: w_rst_pipe = 1'b1;
            default: ;
        endcase
    end

    assign stall      = w_stall;
    assign stall_ex   = w_stall_ex;
    assign stall_ma   = w_stall_ma;
    assign stall_wb   = w_stall_wb;
    assign rst_pipe   = w_rst_pipe;
    assign stall_dly  = r_stall_dly;
    assign stall_fin2 = r_stall_fin2;
    assign ctrl_state = r_state;

endmodule
